regfile_alu: RTL and testbench
==============================

REGFILE_ALU -- requirements
Module: regfile_alu

Interface
- REQ-001 Parameter DW, default 64: data width of registers, ALU operands and results.
- REQ-002 Parameter AW, default 5: register address width, giving 2**AW = 32 registers.
- REQ-003 W_Clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 Reset, input, 1: reset is synchronous and active-high.
- REQ-005 W_En, input, 1: register write enable.
- REQ-006 W_Addr, input, AW: write address.
- REQ-007 WR, input, DW: write data.
- REQ-008 R_Addr, input, AW: read port R address.
- REQ-009 S_Addr, input, AW: read port S address.
- REQ-010 S_Sel, input, 2: ALU S-operand select.
- REQ-011 DS, input, DW: external S operand.
- REQ-012 imm_Op, input, DW: immediate S operand.
- REQ-013 ALU_OP, input, 5: ALU operation code.
- REQ-014 REG_OUT, output, DW: register file port R data; also ALU operand R.
- REQ-015 S, output, DW: register file port S data.
- REQ-016 Y, output, DW: ALU result.
- REQ-017 N, Z, C, V, output, 1 each: negative, zero, carry/borrow and overflow flags.
- REQ-018 SOR, SOL, output, 1 each: bit shifted out on a right shift and on a left shift, respectively.

Function
- REQ-019 Register file: 32 x DW storage; on a W_Clk rising edge with W_En=1 and Reset=0, reg[W_Addr] shall take the value of WR.
- REQ-020 Register file reads: REG_OUT = reg[R_Addr] and S = reg[S_Addr], both combinational.
- REQ-021 Read-during-write on the same address: the read port shall return the old value until the clock edge, unless the feature in REQ-035 is compiled in.
- REQ-022 Register 0 is an ordinary writable register.
- REQ-023 S-operand mux (Sop): S_Sel 00 selects S, 01 selects DS, 10 selects imm_Op, 11 selects S.
- REQ-024 The ALU shall be purely combinational (zero latency), computing Y from REG_OUT and Sop.
- REQ-025 Opcodes:
  - 00: pass Sop
  - 01: pass R
  - 02: Sop+1
  - 03: Sop-1
  - 04: R+Sop
  - 05: R-Sop
  - 06: logical shift right of Sop by 1
  - 07: shift left of Sop by 1
  - 08: R AND Sop
  - 09: R OR Sop
  - 0A: R XOR Sop
  - 0B: NOT Sop
  - 0C: 0-Sop
  - 0D: arithmetic shift right of Sop by 1
  - 0E: Y=0
  - 0F: Y = all ones
  - 10-1F: Y=0, all flags 0
- REQ-026 All arithmetic shall be modulo 2**DW, with no saturation.
- REQ-027 N = Y[DW-1] and Z = (Y==0) for opcodes 00-0F.
- REQ-028 Flag C:
  - ADD and INC: carry out of the MSB.
  - SUB, DEC and NEG: 1 when a borrow occurs (unsigned minuend < subtrahend).
  - Shifts: C equals the shifted-out bit.
  - All other opcodes: C = 0.
- REQ-029 Flag V: two's-complement overflow for ADD, SUB, INC, DEC and NEG; V = 0 for all other opcodes.
- REQ-030 SOR = Sop[0] for opcodes 06 and 0D, else 0.
- REQ-031 SOL = Sop[DW-1] for opcode 07, else 0.

Reset
- REQ-032 On a W_Clk rising edge with Reset=1, all 32 registers shall clear to 0 and the write is ignored.
- REQ-033 Reset has priority over W_En, and asserting it mid-sequence discards any simultaneous write.
- REQ-034 After reset, REG_OUT = S = 0; Y and the flags follow combinationally (for opcode 00 with S_Sel=00: Y=0, Z=1, all other flags 0).

Configuration
- REQ-035 Macro REGFILE_BYPASS_EN:
  - Defined: when W_En=1 and Reset=0 and W_Addr equals R_Addr (or S_Addr), that read port shall return WR combinationally in the same cycle.
  - Undefined: REQ-021 applies.

Structure
- REQ-036 A shared package shall hold the ALU opcode constants (enumerated, 5 bits), the S_Sel encodings, and the DW/AW defaults.
- REQ-037 The ALU shall be a sub-module named alu; the register file, reset and bypass logic shall live in regfile_alu.

Verification
- REQ-038 Reset then read: Reset=1 for one edge, then any R_Addr/S_Addr -> REG_OUT=0 and S=0.
- REQ-039 Write then read: write reg5=0x1234 -> next cycle R_Addr=5 gives REG_OUT=0x1234; same-cycle read gives old value (0), or 0x1234 with REGFILE_BYPASS_EN.
- REQ-040 Add with carry: R=0xFFFF_FFFF_FFFF_FFFF, DS=1, S_Sel=01, op 04 -> Y=0, Z=1, C=1, V=0.
- REQ-041 Signed overflow: R=0x7FFF_FFFF_FFFF_FFFF, imm_Op=1, S_Sel=10, op 04 -> Y=0x8000_0000_0000_0000, N=1, V=1, C=0.
- REQ-042 Subtract with borrow: R=3, Sop=5, op 05 -> Y=0xFFFF_FFFF_FFFF_FFFE, N=1, C=1, V=0.
- REQ-043 Shifts:
  - Sop=0x8000_0000_0000_0001, op 06 -> Y=0x4000_0000_0000_0000, SOR=1.
  - Same Sop, op 07 -> Y=2, SOL=1.
  - Same Sop, op 0D -> Y=0xC000_0000_0000_0000.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// Shared definitions for regfile_alu: width defaults, ALU opcodes and S-operand selects.
package regfile_alu_pkg;

  localparam int DW_DEF = 64;
  localparam int AW_DEF = 5;

  typedef enum logic [4:0] {
    OP_PASS_S = 5'h00,
    OP_PASS_R = 5'h01,
    OP_INC    = 5'h02,
    OP_DEC    = 5'h03,
    OP_ADD    = 5'h04,
    OP_SUB    = 5'h05,
    OP_SHR    = 5'h06,
    OP_SHL    = 5'h07,
    OP_AND    = 5'h08,
    OP_OR     = 5'h09,
    OP_XOR    = 5'h0A,
    OP_NOT    = 5'h0B,
    OP_NEG    = 5'h0C,
    OP_ASR    = 5'h0D,
    OP_ZERO   = 5'h0E,
    OP_ONES   = 5'h0F
  } alu_op_e;

  typedef enum logic [1:0] {
    SSEL_S   = 2'b00,
    SSEL_DS  = 2'b01,
    SSEL_IMM = 2'b10,
    SSEL_S2  = 2'b11
  } ssel_e;

endpackage

// File: rtl/regfile_alu_alu.sv
// Combinational ALU: result Y from operands R and Sop, plus N/Z/C/V and shift-out flags.
module alu
  import regfile_alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] r_i,
  input  logic [DW-1:0] sop_i,
  input  logic [4:0]    op_i,
  output logic [DW-1:0] y_o,
  output logic          n_o,
  output logic          z_o,
  output logic          c_o,
  output logic          v_o,
  output logic          sor_o,
  output logic          sol_o
);

  // Bit DW of each extended result is the carry (add/inc) or the borrow (sub/dec/neg).
  logic [DW:0] sum_w;
  logic [DW:0] diff_w;
  logic [DW:0] inc_w;
  logic [DW:0] dec_w;
  logic [DW:0] neg_w;

  assign sum_w  = {1'b0, r_i} + {1'b0, sop_i};
  assign diff_w = {1'b0, r_i} - {1'b0, sop_i};
  assign inc_w  = {1'b0, sop_i} + (DW+1)'(1);
  assign dec_w  = {1'b0, sop_i} - (DW+1)'(1);
  assign neg_w  = (DW+1)'(0) - {1'b0, sop_i};

  logic [DW-1:0] y;
  logic          c;
  logic          v;
  logic          sor;
  logic          sol;
  logic          valid_op;

  // Opcode decode, result and carry/overflow selection.
  always_comb begin
    y        = '0;
    c        = 1'b0;
    v        = 1'b0;
    sor      = 1'b0;
    sol      = 1'b0;
    valid_op = 1'b1;
    case (op_i)
      OP_PASS_S: y = sop_i;
      OP_PASS_R: y = r_i;
      OP_INC: begin
        y = inc_w[DW-1:0];
        c = inc_w[DW];
        v = ~sop_i[DW-1] & inc_w[DW-1];
      end
      OP_DEC: begin
        y = dec_w[DW-1:0];
        c = dec_w[DW];
        v = sop_i[DW-1] & ~dec_w[DW-1];
      end
      OP_ADD: begin
        y = sum_w[DW-1:0];
        c = sum_w[DW];
        v = ~(r_i[DW-1] ^ sop_i[DW-1]) & (sum_w[DW-1] ^ r_i[DW-1]);
      end
      OP_SUB: begin
        y = diff_w[DW-1:0];
        c = diff_w[DW];
        v = (r_i[DW-1] ^ sop_i[DW-1]) & (diff_w[DW-1] ^ r_i[DW-1]);
      end
      OP_SHR: begin
        y   = {1'b0, sop_i[DW-1:1]};
        c   = sop_i[0];
        sor = sop_i[0];
      end
      OP_SHL: begin
        y   = {sop_i[DW-2:0], 1'b0};
        c   = sop_i[DW-1];
        sol = sop_i[DW-1];
      end
      OP_AND: y = r_i & sop_i;
      OP_OR:  y = r_i | sop_i;
      OP_XOR: y = r_i ^ sop_i;
      OP_NOT: y = ~sop_i;
      OP_NEG: begin
        y = neg_w[DW-1:0];
        c = neg_w[DW];
        v = sop_i[DW-1] & neg_w[DW-1];
      end
      OP_ASR: begin
        y   = {sop_i[DW-1], sop_i[DW-1:1]};
        c   = sop_i[0];
        sor = sop_i[0];
      end
      OP_ZERO: y = '0;
      OP_ONES: y = '1;
      default: valid_op = 1'b0;
    endcase
  end

  // Reserved opcodes force every flag low, including Z.
  assign y_o   = y;
  assign n_o   = valid_op & y[DW-1];
  assign z_o   = valid_op & (y == '0);
  assign c_o   = c;
  assign v_o   = v;
  assign sor_o = sor;
  assign sol_o = sol;

endmodule

// File: rtl/regfile_alu.sv
// 32-entry register file with two combinational read ports feeding the ALU.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_alu
  import regfile_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          W_Clk,
  input  logic          Reset,
  input  logic          W_En,
  input  logic [AW-1:0] W_Addr,
  input  logic [DW-1:0] WR,
  input  logic [AW-1:0] R_Addr,
  input  logic [AW-1:0] S_Addr,
  input  logic [1:0]    S_Sel,
  input  logic [DW-1:0] DS,
  input  logic [DW-1:0] imm_Op,
  input  logic [4:0]    ALU_OP,
  output logic [DW-1:0] REG_OUT,
  output logic [DW-1:0] S,
  output logic [DW-1:0] Y,
  output logic          N,
  output logic          Z,
  output logic          C,
  output logic          V,
  output logic          SOR,
  output logic          SOL
);

  localparam int NREG = 2**AW;

  logic [DW-1:0] regs_q [NREG];

  // Reset wins over a simultaneous write.
  always_ff @(posedge W_Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (W_En) begin
      regs_q[W_Addr] <= WR;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live = W_En & ~Reset;
  assign REG_OUT = (wr_live && (W_Addr == R_Addr)) ? WR : regs_q[R_Addr];
  assign S       = (wr_live && (W_Addr == S_Addr)) ? WR : regs_q[S_Addr];
`else
  assign REG_OUT = regs_q[R_Addr];
  assign S       = regs_q[S_Addr];
`endif

  logic [DW-1:0] sop;

  always_comb begin
    sop = S;
    case (S_Sel)
      SSEL_S:   sop = S;
      SSEL_DS:  sop = DS;
      SSEL_IMM: sop = imm_Op;
      default:  sop = S;
    endcase
  end

  alu #(.DW(DW)) u_alu (
    .r_i   (REG_OUT),
    .sop_i (sop),
    .op_i  (ALU_OP),
    .y_o   (Y),
    .n_o   (N),
    .z_o   (Z),
    .c_o   (C),
    .v_o   (V),
    .sor_o (SOR),
    .sol_o (SOL)
  );

endmodule

// File: tb/tb_regfile_alu.sv
// Self-checking bench for regfile_alu: directed corner cases plus randomized traffic
// compared against an arithmetic reference model of the register file and ALU.
module tb_regfile_alu;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          W_Clk = 1'b0;
  logic          Reset;
  logic          W_En;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] WR;
  logic [AW-1:0] R_Addr;
  logic [AW-1:0] S_Addr;
  logic [1:0]    S_Sel;
  logic [DW-1:0] DS;
  logic [DW-1:0] imm_Op;
  logic [4:0]    ALU_OP;
  logic [DW-1:0] REG_OUT;
  logic [DW-1:0] S;
  logic [DW-1:0] Y;
  logic          N, Z, C, V, SOR, SOL;
  logic [5:0]    flags_s;

  assign flags_s = {N, Z, C, V, SOR, SOL};

  regfile_alu #(.DW(DW), .AW(AW)) dut (
    .W_Clk   (W_Clk),
    .Reset   (Reset),
    .W_En    (W_En),
    .W_Addr  (W_Addr),
    .WR      (WR),
    .R_Addr  (R_Addr),
    .S_Addr  (S_Addr),
    .S_Sel   (S_Sel),
    .DS      (DS),
    .imm_Op  (imm_Op),
    .ALU_OP  (ALU_OP),
    .REG_OUT (REG_OUT),
    .S       (S),
    .Y       (Y),
    .N       (N),
    .Z       (Z),
    .C       (C),
    .V       (V),
    .SOR     (SOR),
    .SOL     (SOL)
  );

  always #5 W_Clk = ~W_Clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl [32];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic signed [64:0] sx(input logic [63:0] x);
    return $signed({x[63], x});
  endfunction

  function automatic logic ovf(input logic signed [64:0] r);
    return (r > $signed(65'h0_7FFF_FFFF_FFFF_FFFF)) || (r < $signed(65'h1_8000_0000_0000_0000));
  endfunction

  // Reference ALU: fl = {N,Z,C,V,SOR,SOL}
  function automatic void ref_alu(input logic [4:0] op, input logic [63:0] r, input logic [63:0] sop,
                                  output logic [63:0] y, output logic [5:0] fl);
    logic [64:0] u;
    logic c, v, sor, sol;
    y = '0; c = 1'b0; v = 1'b0; sor = 1'b0; sol = 1'b0; u = '0;
    case (op)
      5'h00: y = sop;
      5'h01: y = r;
      5'h02: begin u = {1'b0, sop} + 65'd1; y = u[63:0]; c = u[64]; v = ovf(sx(sop) + 65'sd1); end
      5'h03: begin y = sop - 64'd1; c = (sop < 64'd1); v = ovf(sx(sop) - 65'sd1); end
      5'h04: begin u = {1'b0, r} + {1'b0, sop}; y = u[63:0]; c = u[64]; v = ovf(sx(r) + sx(sop)); end
      5'h05: begin y = r - sop; c = (r < sop); v = ovf(sx(r) - sx(sop)); end
      5'h06: begin y = sop / 64'd2; c = sop[0]; sor = sop[0]; end
      5'h07: begin y = sop * 64'd2; c = sop[63]; sol = sop[63]; end
      5'h08: y = r & sop;
      5'h09: y = r | sop;
      5'h0A: y = r ^ sop;
      5'h0B: y = ~sop;
      5'h0C: begin y = 64'd0 - sop; c = (sop != 64'd0); v = ovf(65'sd0 - sx(sop)); end
      5'h0D: begin y = $signed(sop) >>> 1; c = sop[0]; sor = sop[0]; end
      5'h0E: y = 64'd0;
      5'h0F: y = {64{1'b1}};
      default: begin y = 64'd0; fl = 6'd0; return; end
    endcase
    fl = {y[63], (y == 64'd0), c, v, sor, sol};
  endfunction

  // Compare every DUT output against the model for the current inputs.
  task automatic check_all(input string tag);
    logic [63:0] er, es, sop, ey;
    logic [5:0] ef;
    er = mdl[R_Addr];
    es = mdl[S_Addr];
`ifdef REGFILE_BYPASS_EN
    if (W_En && !Reset && (W_Addr == R_Addr)) er = WR;
    if (W_En && !Reset && (W_Addr == S_Addr)) es = WR;
`endif
    case (S_Sel)
      2'b01:   sop = DS;
      2'b10:   sop = imm_Op;
      default: sop = es;
    endcase
    ref_alu(ALU_OP, er, sop, ey, ef);
    #4;
    check_eq({tag, "_reg_out"}, REG_OUT, er);
    check_eq({tag, "_s"}, S, es);
    check_eq({tag, "_y"}, Y, ey);
    check_eq({tag, "_flags"}, 64'(flags_s), 64'(ef));
  endtask

  task automatic tick();
    @(posedge W_Clk);
    if (Reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (W_En) begin
      mdl[W_Addr] = WR;
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    W_En = 1'b1; W_Addr = a; WR = d;
    tick();
    W_En = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] x;
    case ($urandom_range(0, 7))
      0: x = 64'h0;
      1: x = {64{1'b1}};
      2: x = 64'h7FFF_FFFF_FFFF_FFFF;
      3: x = 64'h8000_0000_0000_0000;
      4: x = 64'h1;
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = {$urandom, $urandom};
    Reset = 1'b1; W_En = 1'b1; W_Addr = 5'd7; WR = 64'hDEAD_BEEF;
    R_Addr = 5'd7; S_Addr = 5'd0; S_Sel = 2'b00; DS = '0; imm_Op = '0; ALU_OP = 5'h00;
    @(posedge W_Clk); #1;
    tick();
    Reset = 1'b0; W_En = 1'b0;

    // Reset state, including the write discarded by reset
    #4;
    check_eq("rst_reg_out", REG_OUT, 64'd0);
    check_eq("rst_s", S, 64'd0);
    check_eq("rst_y", Y, 64'd0);
    check_eq("rst_flags", 64'(flags_s), 64'(6'b010000));
    tick();

    // Write then read, with the same-cycle view
    W_En = 1'b1; W_Addr = 5'd5; WR = 64'h1234; R_Addr = 5'd5; #4;
`ifdef REGFILE_BYPASS_EN
    check_eq("wr_same_cycle", REG_OUT, 64'h1234);
`else
    check_eq("wr_same_cycle", REG_OUT, 64'd0);
`endif
    tick();
    W_En = 1'b0; #4;
    check_eq("wr_next_cycle", REG_OUT, 64'h1234);
    tick();

    wr(5'd1, {64{1'b1}});
    wr(5'd2, 64'h7FFF_FFFF_FFFF_FFFF);
    wr(5'd3, 64'd3);
    wr(5'd4, 64'd5);
    wr(5'd0, 64'hA5A5);

    R_Addr = 5'd0; #4;
    check_eq("reg0_writable", REG_OUT, 64'hA5A5);
    R_Addr = 5'd1; DS = 64'd1; S_Sel = 2'b01; ALU_OP = 5'h04; #1;
    check_eq("add_carry_y", Y, 64'd0);
    check_eq("add_carry_flags", 64'(flags_s), 64'(6'b011000));
    R_Addr = 5'd2; imm_Op = 64'd1; S_Sel = 2'b10; #1;
    check_eq("add_ovf_y", Y, 64'h8000_0000_0000_0000);
    check_eq("add_ovf_flags", 64'(flags_s), 64'(6'b100100));
    R_Addr = 5'd3; S_Addr = 5'd4; S_Sel = 2'b00; ALU_OP = 5'h05; #1;
    check_eq("sub_borrow_y", Y, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("sub_borrow_flags", 64'(flags_s), 64'(6'b101000));
    DS = 64'h8000_0000_0000_0001; S_Sel = 2'b01; ALU_OP = 5'h06; #1;
    check_eq("shr_y", Y, 64'h4000_0000_0000_0000);
    check_eq("shr_flags", 64'(flags_s), 64'(6'b001010));
    ALU_OP = 5'h07; #1;
    check_eq("shl_y", Y, 64'd2);
    check_eq("shl_flags", 64'(flags_s), 64'(6'b001001));
    ALU_OP = 5'h0D; #1;
    check_eq("asr_y", Y, 64'hC000_0000_0000_0000);
    check_eq("asr_flags", 64'(flags_s), 64'(6'b101010));
    ALU_OP = 5'h15; #1;
    check_eq("resv_y", Y, 64'd0);
    check_eq("resv_flags", 64'(flags_s), 64'(6'b000000));
    tick();

    // Randomized traffic including occasional reset with a competing write
    for (int it = 0; it < 300; it++) begin
      Reset  = ($urandom_range(0, 24) == 0);
      W_En   = $urandom_range(0, 1) == 1;
      W_Addr = 5'($urandom_range(0, 31));
      WR     = rnd64();
      R_Addr = ($urandom_range(0, 3) == 0) ? W_Addr : 5'($urandom_range(0, 31));
      S_Addr = ($urandom_range(0, 3) == 0) ? W_Addr : 5'($urandom_range(0, 31));
      S_Sel  = 2'($urandom_range(0, 3));
      DS     = rnd64();
      imm_Op = rnd64();
      ALU_OP = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      check_all("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
